// File: rtl/pif_wb_pkg.sv
// Shared constants for the PIF Wishbone/EFB I2C bridge: FSM encoding, EFB
// register map, CMDR values and status-register bit positions.
package pif_wb_pkg;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_INIT1  = 4'd1,
    S_INIT2  = 4'd2,
    S_INIT3  = 4'd3,
    S_INIT4  = 4'd4,
    S_IDLE   = 4'd5,
    S_WAITTR = 4'd6,
    S_IN0    = 4'd7,
    S_OUT0   = 4'd8,
    S_OUT1   = 4'd9,
    S_RD     = 4'd10,
    S_WR     = 4'd11
  } state_t;

  // EFB I2C port register offsets from the port base
  localparam logic [7:0] OFS_CR    = 8'h00;
  localparam logic [7:0] OFS_CMDR  = 8'h01;
  localparam logic [7:0] OFS_BR0   = 8'h02;
  localparam logic [7:0] OFS_BR1   = 8'h03;
  localparam logic [7:0] OFS_TXDR  = 8'h04;
  localparam logic [7:0] OFS_SR    = 8'h05;
  localparam logic [7:0] OFS_GCDR  = 8'h06;
  localparam logic [7:0] OFS_RXDR  = 8'h07;
  localparam logic [7:0] OFS_IRQ   = 8'h08;
  localparam logic [7:0] OFS_IRQEN = 8'h09;

  // EFB configuration registers
  localparam logic [7:0] CFG_CR    = 8'h70;
  localparam logic [7:0] CFG_TXDR  = 8'h71;
  localparam logic [7:0] CFG_SR    = 8'h72;
  localparam logic [7:0] CFG_RXDR  = 8'h73;
  localparam logic [7:0] CFG_IRQ   = 8'h74;
  localparam logic [7:0] CFG_IRQEN = 8'h75;

  // CMDR values: clock-stretch disable, and plain (no command)
  localparam logic [7:0] CMDR_CKSDIS = 8'h04;
  localparam logic [7:0] CMDR_NONE   = 8'h00;

  // SR bit positions
  localparam int SR_TIP   = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_RARC  = 5;
  localparam int SR_SRW   = 4;
  localparam int SR_TRRDY = 2;
  localparam int SR_TROE  = 1;

  typedef struct packed {
    logic busy;
    logic txr;
    logic rxr;
    logic nak;
  } sr_flags_t;

endpackage

// File: rtl/pif_wb_master.sv
// Single-transfer Wishbone master: one request per start pulse, ack or
// timeout ends it. done/tmo are combinational in the terminating cycle.
module pif_wb_master
  import pif_wb_pkg::*;
#(
  parameter int ACK_TMO = 255
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic       clr,
  input  logic       start,
  input  logic       we,
  input  logic [7:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic [7:0] rdat,
  output logic       tmo,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam int CW = $clog2(ACK_TMO + 1);

  logic          act_q, act_d;
  logic          we_q, we_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Handshake: launch on start, end on ack or when the wait count expires
  always_comb begin
    act_d = act_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    tmo   = 1'b0;
    if (clr) begin
      act_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
      cnt_d = '0;
    end else if (act_q) begin
      if (wb_ack_i) begin
        act_d = 1'b0;
        we_d  = 1'b0;
        done  = 1'b1;
      end else if (cnt_q == CW'(ACK_TMO - 1)) begin
        // counter would reach ACK_TMO this edge: give up
        act_d = 1'b0;
        we_d  = 1'b0;
        tmo   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start) begin
      act_d = 1'b1;
      we_d  = we;
      adr_d = adr;
      dat_d = wdat;
      cnt_d = '0;
    end
  end

  // Bus state register; async reset drops cyc/stb without a clock
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      act_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      act_q <= act_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdat     = wb_dat_i;
  assign wb_cyc_o = act_q;
  assign wb_stb_o = act_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: rtl/pif_wb_i2c_bridge.sv
// EFB I2C slave port poller: drives the EFB over Wishbone, decodes
// type-tagged incoming bytes into XI address/data strobes and reports
// transmitted bytes back to the XI side.
module pif_wb_i2c_bridge
  import pif_wb_pkg::*;
#(
  parameter logic [7:0]           EFB_BASE  = 8'h40,
  parameter int                   TYPE_BITS = 2,
  parameter logic [TYPE_BITS-1:0] A_CODE    = 2'b01,
  parameter logic [TYPE_BITS-1:0] D_CODE    = 2'b10,
  parameter int                   ADDR_W    = 6,
  parameter int                   SUBA_MAX  = 3,
  parameter int                   SUBA_W    = 2,
  parameter int                   ACK_TMO   = 255,
  parameter int                   RST_CYC   = 16
) (
  input  logic                  xclk,
  input  logic                  sys_rst,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [7:0]            wb_adr_o,
  output logic [7:0]            wb_dat_o,
  input  logic [7:0]            wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic [7:0]            xo,
  output logic                  xi_pwr,
  output logic [ADDR_W-1:0]     xi_prwa,
  output logic                  xi_prd_finished,
  output logic [SUBA_W-1:0]     xi_prd_suba,
  output logic [7-TYPE_BITS:0]  xi_pd,
  output logic                  wb_tmo,
  output logic                  nak_seen
);

  localparam int DW = 8 - TYPE_BITS;
  localparam logic [7:0] ADR_CMDR = EFB_BASE + OFS_CMDR;
  localparam logic [7:0] ADR_TXDR = EFB_BASE + OFS_TXDR;
  localparam logic [7:0] ADR_SR   = EFB_BASE + OFS_SR;
  localparam logic [7:0] ADR_RXDR = EFB_BASE + OFS_RXDR;

  logic [RST_CYC-1:0] rst_sr_q, rst_sr_d;
  logic               rst;

  state_t     state_q, state_d, ret_q, ret_d;
  logic       m_start, m_we, m_done, m_tmo;
  logic [7:0] m_adr, m_wdat, m_rdat;
  logic       rd_sr, nak_set;

  sr_flags_t   sr_f, flg_q, flg_d;
  logic        is_a_q, is_a_d, is_d_q, is_d_d;
  logic [DW-1:0] rx_q, rx_d;

  logic [ADDR_W-1:0] rw_addr_q, rw_addr_d, prwa_q, prwa_d;
  logic [SUBA_W-1:0] rd_suba_q, rd_suba_d, wr_suba_q, wr_suba_d;
  logic [SUBA_W-1:0] prd_suba_q, prd_suba_d;
  logic [DW-1:0]     pd_q, pd_d;
  logic              pwr_q, pwr_d, fin_q, fin_d, nak_q, nak_d, tmo_q, tmo_d;

  pif_wb_master #(.ACK_TMO(ACK_TMO)) u_mst (
    .xclk     (xclk),
    .sys_rst  (sys_rst),
    .clr      (rst),
    .start    (m_start),
    .we       (m_we),
    .adr      (m_adr),
    .wdat     (m_wdat),
    .done     (m_done),
    .rdat     (m_rdat),
    .tmo      (m_tmo),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  // Power-up reset: ones loaded by sys_rst, shifted out one per cycle
  always_comb rst_sr_d = {rst_sr_q[RST_CYC-2:0], 1'b0};
  assign rst = rst_sr_q[RST_CYC-1];

  // Status flags straight from the data bus in the SR ack cycle
  assign sr_f.busy = m_rdat[SR_BUSY];
  assign sr_f.txr  = m_rdat[SR_BUSY] & m_rdat[SR_TRRDY] & m_rdat[SR_SRW] & ~m_rdat[SR_TIP];
  assign sr_f.rxr  = m_rdat[SR_BUSY] & m_rdat[SR_TRRDY] & ~m_rdat[SR_SRW];
  assign sr_f.nak  = m_rdat[SR_BUSY] & m_rdat[SR_RARC] & m_rdat[SR_SRW] & m_rdat[SR_TROE];
  assign rd_sr     = (wb_adr_o == ADR_SR);

  // Control FSM: each bus access parks in RD/WR and resumes at ret_q
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    m_start = 1'b0;
    m_we    = 1'b0;
    m_adr   = ADR_SR;
    m_wdat  = 8'h00;
    nak_set = 1'b0;
    case (state_q)
      S_START: begin
        m_start = 1'b1; m_we = 1'b1; m_adr = ADR_CMDR; m_wdat = CMDR_CKSDIS;
        ret_d = S_INIT1; state_d = S_WR;
      end
      S_INIT1: begin
        m_start = 1'b1; ret_d = S_INIT2; state_d = S_RD;
      end
      S_INIT2: begin
        m_start = 1'b1; state_d = S_RD;
        if (flg_q.busy) ret_d = S_INIT2;
        else begin m_adr = ADR_RXDR; ret_d = S_INIT3; end
      end
      S_INIT3: begin
        m_start = 1'b1; m_adr = ADR_RXDR; ret_d = S_INIT4; state_d = S_RD;
      end
      S_INIT4: begin
        m_start = 1'b1; m_we = 1'b1; m_adr = ADR_CMDR; m_wdat = CMDR_NONE;
        ret_d = S_IDLE; state_d = S_WR;
      end
      S_IDLE: begin
        // the busy decision is taken in the SR ack cycle, see S_RD
        m_start = 1'b1; ret_d = S_IDLE; state_d = S_RD;
      end
      S_WAITTR: begin
        if (flg_q.nak) begin
          nak_set = 1'b1; state_d = S_START;
        end else if (flg_q.txr) begin
          m_start = 1'b1; m_we = 1'b1; m_adr = ADR_TXDR; m_wdat = xo;
          ret_d = S_OUT0; state_d = S_WR;
        end else if (flg_q.rxr) begin
          m_start = 1'b1; m_adr = ADR_RXDR; ret_d = S_IN0; state_d = S_RD;
        end else if (!flg_q.busy) begin
          state_d = S_START;
        end else begin
          m_start = 1'b1; ret_d = S_WAITTR; state_d = S_RD;
        end
      end
      S_IN0:  state_d = S_IDLE;
      S_OUT0: state_d = S_OUT1;
      S_OUT1: state_d = S_IDLE;
      S_RD, S_WR: begin
        if (m_done) begin
          state_d = ret_q;
          if (state_q == S_RD && ret_q == S_IDLE && sr_f.busy) state_d = S_WAITTR;
        end else if (m_tmo) begin
          state_d = S_START;
        end
      end
      default: state_d = S_START;
    endcase
    if (rst) begin
      state_d = S_START;
      ret_d   = S_START;
      m_start = 1'b0;
    end
  end

  // Capture status flags or the classified RXDR byte on read ack
  always_comb begin
    flg_d  = flg_q;
    is_a_d = is_a_q;
    is_d_d = is_d_q;
    rx_d   = rx_q;
    if (state_q == S_RD && m_done) begin
      if (rd_sr) flg_d = sr_f;
      else begin
        is_a_d = (m_rdat[7 -: TYPE_BITS] == A_CODE);
        is_d_d = (m_rdat[7 -: TYPE_BITS] == D_CODE);
        rx_d   = m_rdat[DW-1:0];
      end
    end
    if (rst) begin
      flg_d  = '0;
      is_a_d = 1'b0;
      is_d_d = 1'b0;
      rx_d   = '0;
    end
  end

  // XI side: address/data strobes, sub-address counters, status outputs
  always_comb begin
    rw_addr_d  = rw_addr_q;
    rd_suba_d  = rd_suba_q;
    wr_suba_d  = wr_suba_q;
    pd_d       = pd_q;
    pwr_d      = 1'b0;
    fin_d      = (state_q == S_OUT0);
    nak_d      = nak_q | nak_set;
    tmo_d      = m_tmo;
    prwa_d     = rw_addr_q;
    prd_suba_d = rd_suba_q;
    if (fin_q) rd_suba_d = (rd_suba_q == SUBA_W'(SUBA_MAX)) ? '0 : rd_suba_q + 1'b1;
    if (pwr_q) wr_suba_d = (wr_suba_q == SUBA_W'(SUBA_MAX)) ? '0 : wr_suba_q + 1'b1;
    if (state_q == S_IN0 && is_a_q) begin
      // a new address restarts both sub-address sequences
      rw_addr_d = rx_q[ADDR_W-1:0];
      rd_suba_d = '0;
      wr_suba_d = '0;
      nak_d     = 1'b0;
    end
    if (state_q == S_IN0 && is_d_q) begin
      pd_d  = rx_q;
      pwr_d = 1'b1;
    end
    if (rst) begin
      rw_addr_d  = '0;
      rd_suba_d  = '0;
      wr_suba_d  = '0;
      pd_d       = '0;
      pwr_d      = 1'b0;
      fin_d      = 1'b0;
      nak_d      = 1'b0;
      tmo_d      = 1'b0;
      prwa_d     = '0;
      prd_suba_d = '0;
    end
  end

  // State registers
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      rst_sr_q   <= '1;
      state_q    <= S_START;
      ret_q      <= S_START;
      flg_q      <= '0;
      is_a_q     <= 1'b0;
      is_d_q     <= 1'b0;
      rx_q       <= '0;
      rw_addr_q  <= '0;
      rd_suba_q  <= '0;
      wr_suba_q  <= '0;
      pd_q       <= '0;
      pwr_q      <= 1'b0;
      fin_q      <= 1'b0;
      nak_q      <= 1'b0;
      tmo_q      <= 1'b0;
      prwa_q     <= '0;
      prd_suba_q <= '0;
    end else begin
      rst_sr_q   <= rst_sr_d;
      state_q    <= state_d;
      ret_q      <= ret_d;
      flg_q      <= flg_d;
      is_a_q     <= is_a_d;
      is_d_q     <= is_d_d;
      rx_q       <= rx_d;
      rw_addr_q  <= rw_addr_d;
      rd_suba_q  <= rd_suba_d;
      wr_suba_q  <= wr_suba_d;
      pd_q       <= pd_d;
      pwr_q      <= pwr_d;
      fin_q      <= fin_d;
      nak_q      <= nak_d;
      tmo_q      <= tmo_d;
      prwa_q     <= prwa_d;
      prd_suba_q <= prd_suba_d;
    end
  end

  assign xi_pwr          = pwr_q;
  assign xi_prwa         = prwa_q;
  assign xi_prd_finished = fin_q;
  assign xi_prd_suba     = prd_suba_q;
  assign xi_pd           = pd_q;
  assign wb_tmo          = tmo_q;
  assign nak_seen        = nak_q;

endmodule

// File: tb/tb_pif_wb_i2c_bridge.sv
// Directed bench: a scoreboard queue holds the expected Wishbone accesses
// with their read responses; the EFB model pops one per strobe.
module tb_pif_wb_i2c_bridge;

  logic       xclk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_ack_i = 1'b0;
  logic [7:0] xo = 8'h00;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0] wb_adr_o, wb_dat_o;
  logic       xi_pwr, xi_prd_finished, wb_tmo, nak_seen;
  logic [5:0] xi_prwa, xi_pd;
  logic [1:0] xi_prd_suba;

  logic       d2_cyc, d2_stb, d2_we, d2_pwr, d2_fin, d2_tmo, d2_nak;
  logic [7:0] d2_adr, d2_dat;
  logic [5:0] d2_prwa, d2_pd;
  logic [1:0] d2_suba;
  logic [7:0] zero8 = 8'h00;
  logic       zero1 = 1'b0;

  always #5 xclk = ~xclk;

  pif_wb_i2c_bridge u_dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .xo(xo), .xi_pwr(xi_pwr), .xi_prwa(xi_prwa), .xi_prd_finished(xi_prd_finished),
    .xi_prd_suba(xi_prd_suba), .xi_pd(xi_pd), .wb_tmo(wb_tmo), .nak_seen(nak_seen)
  );

  pif_wb_i2c_bridge #(.EFB_BASE(8'h4A)) u_dut2 (
    .xclk(xclk), .sys_rst(sys_rst),
    .wb_cyc_o(d2_cyc), .wb_stb_o(d2_stb), .wb_we_o(d2_we),
    .wb_adr_o(d2_adr), .wb_dat_o(d2_dat), .wb_dat_i(zero8), .wb_ack_i(zero1),
    .xo(zero8), .xi_pwr(d2_pwr), .xi_prwa(d2_prwa), .xi_prd_finished(d2_fin),
    .xi_prd_suba(d2_suba), .xi_pd(d2_pd), .wb_tmo(d2_tmo), .nak_seen(d2_nak)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [7:0] rsp;
  } sb_t;

  sb_t        sb[$];
  logic [5:0] pd_exp[$];
  int total = 0;
  int bad = 0;
  int pwr_cnt = 0;
  int fin_cnt = 0;
  int tmo_cnt = 0;
  logic no_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] adr, input logic [7:0] dat);
    sb.push_back('{we: 1'b1, adr: adr, dat: dat, rsp: 8'h00});
  endtask

  task automatic push_r(input logic [7:0] adr, input logic [7:0] rsp);
    sb.push_back('{we: 1'b0, adr: adr, dat: 8'h00, rsp: rsp});
  endtask

  // START..INIT4 sequence with an idle EFB
  task automatic push_init();
    push_w(8'h41, 8'h04);
    push_r(8'h45, 8'h00);
    push_r(8'h47, 8'h00);
    push_r(8'h47, 8'h00);
    push_w(8'h41, 8'h00);
  endtask

  // one clock: sample XI side, then play the EFB at the falling edge
  task automatic cyc();
    sb_t e;
    @(negedge xclk);
    if (xi_pwr) begin
      pwr_cnt++;
      if (pd_exp.size() > 0) chk("xi_pd", 32'(xi_pd), 32'(pd_exp.pop_front()));
      else chk("xi_pwr_unexpected", 32'(xi_pwr), 32'(0));
    end
    if (xi_prd_finished) fin_cnt++;
    if (wb_tmo) tmo_cnt++;
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
    end else if (wb_stb_o && !no_ack) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_txn", 32'({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 8'h00}),
                      32'({e.we, e.adr, e.we ? e.dat : 8'h00}));
        wb_dat_i = e.rsp;
      end else begin
        chk("sb_idle_poll", 32'({wb_we_o, wb_adr_o}), 32'({1'b0, 8'h45}));
        wb_dat_i = 8'h00;
      end
      wb_ack_i = 1'b1;
    end
  endtask

  task automatic wait_sb_empty(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin cyc(); n++; end
    chk(tag, 32'(sb.size()), 32'(0));
    repeat (10) cyc();
  endtask

  initial begin
    int n;
    int hi;
    xo = 8'hA5;
    push_init();
    repeat (3) @(negedge xclk);
    sys_rst = 1'b1;

    // power-up hold: everything quiet for RST_CYC cycles
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("rst_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 32'(0));
      chk("rst_xi", 32'({xi_pwr, xi_prwa, xi_prd_finished, xi_prd_suba, xi_pd, wb_tmo, nak_seen}), 32'(0));
      chk("rst_d2_bus", 32'({d2_cyc, d2_stb, d2_we, d2_adr, d2_dat}), 32'(0));
      chk("rst_d2_xi", 32'({d2_pwr, d2_prwa, d2_fin, d2_suba, d2_pd, d2_tmo, d2_nak}), 32'(0));
    end

    // I2C2 instance: first access is the CMDR write at base+1
    n = 0;
    while (!d2_stb && n < 50) begin cyc(); n++; end
    chk("i2c2_first", 32'({d2_we, d2_adr, d2_dat}), 32'({1'b1, 8'h4B, 8'h04}));
    wait_sb_empty("init_drain");

    // address byte 0x45 -> addr 5
    push_r(8'h45, 8'h44);
    push_r(8'h47, 8'h45);
    wait_sb_empty("addr_drain");
    chk("prwa_5", 32'(xi_prwa), 32'(5));

    // data byte 0x9A -> pd 0x1A, one write strobe
    pd_exp.push_back(6'h1A);
    push_r(8'h45, 8'h44);
    push_r(8'h47, 8'h9A);
    wait_sb_empty("data_drain");
    chk("pwr_count", 32'(pwr_cnt), 32'(1));
    chk("pd_hold", 32'(xi_pd), 32'(6'h1A));
    chk("wr_suba", 32'(u_dut.wr_suba_q), 32'(1));

    // four transmits, read sub-address wraps after 3
    for (int i = 0; i < 4; i++) begin
      push_r(8'h45, 8'h54);
      push_w(8'h44, 8'hA5);
      wait_sb_empty("tx_drain");
      chk("fin_count", 32'(fin_cnt), 32'(i + 1));
      chk("prd_suba", 32'(xi_prd_suba), 32'((i + 1) % 4));
    end

    // master NAK: sticky flag, full restart, cleared by next address
    push_r(8'h45, 8'h72);
    push_init();
    wait_sb_empty("nak_drain");
    chk("nak_set", 32'(nak_seen), 32'(1));
    push_r(8'h45, 8'h44);
    push_r(8'h47, 8'h43);
    wait_sb_empty("nak_clr_drain");
    chk("nak_clr", 32'(nak_seen), 32'(0));
    chk("prwa_3", 32'(xi_prwa), 32'(3));

    // ack timeout: strobe held exactly ACK_TMO cycles, then restart
    no_ack = 1'b1;
    cyc();
    n = 0;
    while (!wb_stb_o && n < 100) begin cyc(); n++; end
    hi = 0;
    while (wb_stb_o && hi < 1000) begin cyc(); hi++; end
    chk("tmo_len", 32'(hi), 32'(255));
    no_ack = 1'b0;
    push_init();
    wait_sb_empty("tmo_restart");
    chk("tmo_pulses", 32'(tmo_cnt), 32'(1));

    // async reset in the middle of a read
    n = 0;
    while (!wb_stb_o && n < 100) begin cyc(); n++; end
    #2 sys_rst = 1'b0;
    #1;
    chk("rst_async_bus", 32'({wb_cyc_o, wb_stb_o}), 32'(0));
    chk("rst_async_pwr", 32'(xi_pwr), 32'(0));
    wb_ack_i = 1'b0;
    repeat (3) cyc();
    chk("rst_prwa", 32'(xi_prwa), 32'(0));
    sys_rst = 1'b1;
    push_init();
    wait_sb_empty("rst_restart");
    chk("pwr_final", 32'(pwr_cnt), 32'(1));
    chk("tmo_final", 32'(tmo_cnt), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pif_wb_i2c_bridge.md
Name: pif_wb_i2c_bridge

Overview:
- Parametrised Wishbone master that services one MachXO2 EFB I2C slave port (I2C1 or I2C2, selected by parameter) and converts I2C traffic into the PIF XI register-bus strobes.
- Successor to the fixed I2C1 bridge. The EFB is instantiated outside this block, so the Wishbone bus is exposed as ports.
- New behaviour over the fixed bridge: generic type/data split, configurable sub-address wrap, Wishbone ack timeout with recovery, and an error/NAK status output.

Parameters:
- EFB_BASE, 8'h40, I2C port register base. Use 8'h40 for I2C1 and 8'h4A for I2C2. CR/CMDR/TXDR/SR/RXDR sit at offsets +0/+1/+4/+5/+7.
- TYPE_BITS, 2, number of MSBs of an incoming byte that carry the type code.
- A_CODE, 2'b01, type code meaning "address byte".
- D_CODE, 2'b10, type code meaning "data byte".
- ADDR_W, 6, width of xi_prwa. Must satisfy ADDR_W ≤ 8-TYPE_BITS.
- SUBA_MAX, 3, last sub-address value before wrap to 0.
- SUBA_W, 2, width of the sub-address counters. Must satisfy 2^SUBA_W > SUBA_MAX.
- ACK_TMO, 255, number of cycles to wait for wb_ack_i before aborting.
- RST_CYC, 16, length of the internal power-up reset.

Ports:
- xclk, in, 1, system clock.
- sys_rst, in, 1, asynchronous active-low reset.
- wb_cyc_o, out, 1, Wishbone cycle.
- wb_stb_o, out, 1, Wishbone strobe.
- wb_we_o, out, 1, Wishbone write enable.
- wb_adr_o, out, 8, EFB register address.
- wb_dat_o, out, 8, Wishbone write data.
- wb_dat_i, in, 8, Wishbone read data.
- wb_ack_i, in, 1, Wishbone acknowledge.
- xo, in, 8, outgoing byte, quasi-static, sampled when TXDR is written.
- xi_pwr, out, 1, single-cycle write strobe.
- xi_prwa, out, ADDR_W, registered register address.
- xi_prd_finished, out, 1, pulse issued after each byte is transmitted.
- xi_prd_suba, out, SUBA_W, read sub-address.
- xi_pd, out, 8-TYPE_BITS, write data.
- wb_tmo, out, 1, one-cycle pulse on Wishbone ack timeout.
- nak_seen, out, 1, sticky flag set when the master NAKs a transmitted byte. Cleared by the next address byte.

Behaviour:
- Reset:
  - sys_rst low asynchronously clears all registers and loads the internal rst shift chain.
  - After deassertion, rst stays high for RST_CYC xclk cycles. During rst the FSM is held in START and every output is 0.
- Wishbone handshake (RD and WR states):
  - Cycle 1: assert cyc/stb, plus we for writes. Hold adr and dat stable until ack.
  - On the ack cycle: deassert all three, capture wb_dat_i for reads, go to the return state.
  - The bus is never re-asserted in the cycle after ack.
  - Timeout counter (width clog2(ACK_TMO+1)) clears on entry to RD or WR. When it reaches ACK_TMO without ack: drop cyc/stb/we, pulse wb_tmo, go to START.
- Status decode:
  - SR is decoded from wb_dat_i in the same ack cycle, not from the previous read.
  - Bit mapping: TIP=7, BUSY=6, RARC=5, SRW=4, TRRDY=2, TROE=1.
  - busy = BUSY.
  - txr = BUSY & TRRDY & SRW & ~TIP.
  - rxr = BUSY & TRRDY & ~SRW.
  - nak = BUSY & RARC & SRW & TROE.
- FSM states and transitions:
  - START: write CMDR=8'h04 → INIT1.
  - INIT1: read SR → INIT2.
  - INIT2: if busy, re-read SR; else read RXDR → INIT3.
  - INIT3: read RXDR → INIT4.
  - INIT4: write CMDR=8'h00 → IDLE.
  - IDLE: read SR. If busy → WAITTR, else → IDLE.
  - WAITTR, first match wins:
    - nak → set nak_seen, go START.
    - txr → write TXDR=xo → OUT0.
    - rxr → read RXDR → IN0.
    - ~busy → START.
    - otherwise read SR → WAITTR.
  - IN0 → IDLE.
  - OUT0 → OUT1.
  - OUT1 → IDLE.
- Incoming byte handling:
  - On the RXDR ack cycle, classify the byte:
    - isA when byte[7:8-TYPE_BITS]==A_CODE.
    - isD when it equals D_CODE.
    - Any other code is ignored.
  - Data is byte[7-TYPE_BITS:0].
  - In IN0 with isA: rwAddr ← data[ADDR_W-1:0]; rd_suba ← 0; wr_suba ← 0; nak_seen ← 0.
  - In IN0 with isD: xi_pd ← data and xi_pwr=1 for exactly one cycle (the cycle after IN0).
- Outgoing byte handling: xi_prd_finished pulses for one cycle, registered from state==OUT0.
- Sub-address counters:
  - rd_suba increments on xi_prd_finished. wr_suba increments on xi_pwr.
  - Each wraps SUBA_MAX → 0.
  - If an address byte and an increment occur in the same cycle, the clear wins.
- Output registering: xi_prwa and xi_prd_suba are registered copies of rwAddr and rd_suba, so they lag by 1 cycle.
- Other boundaries:
  - An ack that arrives outside RD/WR is ignored.
  - sys_rst asserted mid-transfer drops cyc/stb immediately (asynchronously).

Decomposition:
- Shared package pif_wb_pkg holds:
  - FSM state encoding (4-bit localparams).
  - EFB register offsets (CR, CMDR, BR0, BR1, TXDR, SR, GCDR, RXDR, IRQ, IRQEN).
  - CFG register addresses 8'h70–8'h75.
  - CMDR constants CKSDIS=8'h04 and 8'h00.
  - SR bit indices.
- Sub-module pif_wb_master holds the RD/WR handshake and the timeout counter, with the interface start, we, adr, wdat → done, rdat, tmo.
- Top level holds the FSM, the byte decode and the XI counters.

Test Plan:
- Reset: hold sys_rst low 3 cycles, then release → all outputs 0 for 16 cycles; first Wishbone cycle is a write with adr=8'h41, dat=8'h04; with EFB_BASE=8'h4A, adr=8'h4B.
- Address then data: SR=8'h44, RXDR=8'h45 (A_CODE, addr 5), then SR=8'h44, RXDR=8'h9A (D_CODE, data 0x1A) → xi_prwa=5, then a single-cycle xi_pwr with xi_pd=6'h1A and wr_suba incrementing 0→1.
- Transmit: xo=8'hA5, SR=8'h54 four times → four TXDR writes with dat=A5, four xi_prd_finished pulses; xi_prd_suba goes 1,2,3,0 (wrap at SUBA_MAX=3).
- NAK: SR=8'h72 in WAITTR → nak_seen=1, FSM returns to START (CMDR write 8'h04); a subsequent address byte clears nak_seen.
- Timeout: never assert wb_ack_i → cyc/stb drop after exactly 255 cycles, wb_tmo pulses once, FSM restarts at START.
- Reset mid-read: pull sys_rst low while stb=1 → cyc/stb go to 0 with no clock edge needed; bench checks no xi_pwr glitch.
